program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'd0, word address of the first loaded instruction.
REQ-002 SHALL have parameter MAX_WORDS, default 32'd4096, largest accepted word count.
REQ-003 SHALL have parameter ACK_BYTE, default 8'hAA, byte returned on successful load.
REQ-004 SHALL have parameter NAK_BYTE, default 8'hEE, byte returned on rejected length.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port rx_data, input, 8, byte from the UART receiver.
REQ-008 SHALL have port rx_valid, input, 1, one-cycle strobe marking rx_data valid.
REQ-009 SHALL have port wr_en, output, 1, instruction-memory write strobe.
REQ-010 SHALL have port wr_addr, output, 32, instruction-memory word address.
REQ-011 SHALL have port wr_data, output, 32, instruction-memory write data.
REQ-012 SHALL have port tx_data, output, 8, byte to the UART transmitter.
REQ-013 SHALL have port tx_valid, output, 1, tx_data valid; held until tx_ready.
REQ-014 SHALL have port tx_ready, input, 1, transmitter accepts tx_data when high with tx_valid.
REQ-015 SHALL have port core_start, output, 1, level that releases the core from hold.
REQ-016 SHALL have port load_err, output, 1, sticky flag for a rejected length.

Function
REQ-017 SHALL implement states LEN, DATA, ACK, DONE, ERR.
REQ-018 SHALL, in LEN, take 4 bytes little-endian (first byte = bits 7:0) as word count N.
REQ-019 SHALL, on the 4th LEN byte, go to DATA if 1 <= N <= MAX_WORDS, to ACK if N = 0, else to ERR.
REQ-020 SHALL, in DATA, assemble each group of 4 bytes little-endian into one 32-bit word.
REQ-021 SHALL assert wr_en for exactly one cycle, the cycle after the 4th byte of a word is accepted.
REQ-022 SHALL, in the wr_en cycle, drive wr_addr = ADDR_BASE + k (k = 0-based word index, mod 2^32) and wr_data = the assembled word.
REQ-023 SHALL hold wr_addr and wr_data stable while wr_en is low; their values then carry no meaning.
REQ-024 SHALL go from DATA to ACK in the same cycle it asserts wr_en for word N-1.
REQ-025 SHALL, in ACK, drive tx_data = ACK_BYTE with tx_valid = 1 until tx_valid && tx_ready, then go to DONE.
REQ-026 SHALL, in ERR, set load_err = 1 and drive tx_data = NAK_BYTE with tx_valid = 1 until accepted, then stay in ERR with tx_valid = 0.
REQ-027 SHALL, in DONE, hold core_start = 1 until reset.
REQ-028 SHALL ignore rx_valid in ACK, DONE and ERR; no byte is buffered.
REQ-029 SHALL treat rx_valid high on consecutive cycles as distinct bytes, one byte per cycle, with no loss.
REQ-030 SHALL accept a new byte in the same cycle wr_en is high for the previous word.
REQ-031 SHALL keep the byte count within a word and the word count free-running across idle gaps of any length.

Reset
REQ-032 SHALL, while rst is high at a clock edge, enter LEN and clear the byte count, word count and N.
REQ-033 SHALL, while rst is high, drive wr_en = 0, wr_addr = 0, wr_data = 0, tx_valid = 0, tx_data = 0, core_start = 0 and load_err = 0.
REQ-034 SHALL, on reset mid-load, discard the partial word, with no wr_en after reset until 4 new data bytes are received.

Verification
REQ-035 SHALL cover: bytes 02 00 00 00, 13 00 00 00, 93 00 10 00, then tx_ready=1 -> wr_en at addr 0 data 0x00000013, then addr 1 data 0x00100093; one tx of 0xAA; core_start=1.
REQ-036 SHALL cover: bytes 00 00 00 00 -> no wr_en; 0xAA sent; core_start=1.
REQ-037 SHALL cover: MAX_WORDS=4 with bytes 05 00 00 00 -> load_err=1; one tx of 0xEE; no wr_en; core_start stays 0.
REQ-038 SHALL cover: N=1, 4 data bytes on consecutive cycles, tx_ready held low 10 cycles -> tx_valid=1 with tx_data=0xAA for all 10 cycles; DONE one cycle after tx_ready rises.
REQ-039 SHALL cover: N=2 with reset after 6 data bytes, then a full N=1 load of bytes 78 56 34 12 -> exactly one wr_en after reset, addr 0, data 0x12345678.
REQ-040 SHALL cover: ADDR_BASE=0x100 with N=3 -> wr_addr values 0x100, 0x101, 0x102 in order.

Source files
------------

// File: rtl/program_loader.sv
// UART boot loader: receives a little-endian word count and that many instruction
// words, writes them to instruction memory, answers ACK/NAK, then releases the core.
module program_loader #(
  parameter logic [31:0] ADDR_BASE = 32'd0,
  parameter logic [31:0] MAX_WORDS = 32'd4096,
  parameter logic [7:0]  ACK_BYTE  = 8'hAA,
  parameter logic [7:0]  NAK_BYTE  = 8'hEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        core_start,
  output logic        load_err
);

  typedef enum logic [2:0] {S_LEN, S_DATA, S_ACK, S_DONE, S_ERR} state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [31:0] n_q, n_d;
  logic [31:0] shift_q, shift_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        nak_sent_q, nak_sent_d;

  logic [31:0] assembled;
  logic        byte_taken;
  logic        last_byte;

  // Bytes shift in from the top so the first byte of a group ends up in bits 7:0.
  assign assembled  = {rx_data, shift_q[31:8]};
  assign byte_taken = rx_valid && (state_q == S_LEN || state_q == S_DATA);
  assign last_byte  = byte_taken && (byte_cnt_q == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_LEN;
    else     state_q <= state_d;
  end

  // NOTE: every signal written in a combinational block gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN: begin
        if (last_byte) begin
          if (assembled == 32'd0)            state_d = S_ACK;
          else if (assembled <= MAX_WORDS)   state_d = S_DATA;
          else                               state_d = S_ERR;
        end
      end
      S_DATA: begin
        if (last_byte && (word_cnt_q == n_q - 32'd1)) state_d = S_ACK;
      end
      S_ACK:   if (tx_ready) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_LEN;
    endcase
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    n_d        = n_q;
    shift_d    = shift_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    nak_sent_d = nak_sent_q;
    if (byte_taken) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = assembled;
    end
    if (last_byte) begin
      if (state_q == S_LEN) begin
        n_d = assembled;
      end else begin
        wr_en_d    = 1'b1;
        wr_addr_d  = ADDR_BASE + word_cnt_q;
        wr_data_d  = assembled;
        word_cnt_d = word_cnt_q + 32'd1;
      end
    end
    if (state_q == S_ERR && tx_ready) nak_sent_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 32'd0;
      n_q        <= 32'd0;
      shift_q    <= 32'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 32'd0;
      wr_data_q  <= 32'd0;
      nak_sent_q <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      n_q        <= n_d;
      shift_q    <= shift_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      nak_sent_q <= nak_sent_d;
    end
  end

  // Outputs are forced low while rst is asserted, even before the first reset edge.
  always_comb begin
    wr_en      = wr_en_q;
    wr_addr    = wr_addr_q;
    wr_data    = wr_data_q;
    tx_valid   = 1'b0;
    tx_data    = 8'd0;
    core_start = 1'b0;
    load_err   = 1'b0;
    case (state_q)
      S_ACK: begin
        tx_valid = 1'b1;
        tx_data  = ACK_BYTE;
      end
      S_DONE: core_start = 1'b1;
      S_ERR: begin
        load_err = 1'b1;
        if (!nak_sent_q) begin
          tx_valid = 1'b1;
          tx_data  = NAK_BYTE;
        end
      end
      default: ;
    endcase
    if (rst) begin
      wr_en      = 1'b0;
      wr_addr    = 32'd0;
      wr_data    = 32'd0;
      tx_valid   = 1'b0;
      tx_data    = 8'd0;
      core_start = 1'b0;
      load_err   = 1'b0;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: two instances (default parameters and
// ADDR_BASE=0x100/MAX_WORDS=4) share one byte stream and are checked independently.
module tb_program_loader;

  localparam logic [7:0] ACK = 8'hAA;
  localparam logic [7:0] NAK = 8'hEE;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_ready;

  logic        wr_en      [2];
  logic [31:0] wr_addr    [2];
  logic [31:0] wr_data    [2];
  logic [7:0]  tx_data    [2];
  logic        tx_valid   [2];
  logic        core_start [2];
  logic        load_err   [2];

  always #5 clk = ~clk;

  program_loader dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready),
    .core_start(core_start[0]), .load_err(load_err[0])
  );

  program_loader #(.ADDR_BASE(32'h100), .MAX_WORDS(32'd4)) dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready),
    .core_start(core_start[1]), .load_err(load_err[1])
  );

  typedef struct {
    logic [31:0]      n;
    int               nw;
    logic [5:0][31:0] w;
    logic             err_a;
    logic             err_b;
    int               cnt_a;
    int               cnt_b;
  } vec_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  string       tag;
  logic [7:0]  stim [$];
  logic [31:0] obs_addr [2][$];
  logic [31:0] obs_data [2][$];
  logic [7:0]  obs_tx   [2][$];
  logic [31:0] exp_addr [2][$];
  logic [31:0] exp_data [2][$];
  logic [7:0]  exp_tx   [2];
  logic        exp_err  [2];
  vec_t        vecs     [8];

  function automatic logic [31:0] base_of(input int i);
    return (i == 0) ? 32'h0 : 32'h100;
  endfunction

  function automatic logic [31:0] max_of(input int i);
    return (i == 0) ? 32'd4096 : 32'd4;
  endfunction

  function automatic vec_t mk(input logic [31:0] n, input int nw, input logic [5:0][31:0] w,
                              input logic ea, input logic eb, input int ca, input int cb);
    vec_t v;
    v.n = n; v.nw = nw; v.w = w; v.err_a = ea; v.err_b = eb; v.cnt_a = ca; v.cnt_b = cb;
    return v;
  endfunction

  // Monitor: every wr_en cycle is one write, every valid&&ready cycle is one byte sent.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en[i]) begin
          obs_addr[i].push_back(wr_addr[i]);
          obs_data[i].push_back(wr_data[i]);
        end
        if (tx_valid[i] && tx_ready) obs_tx[i].push_back(tx_data[i]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) stim.push_back(w[8*b +: 8]);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    tx_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset dut%0d wr_en", i),      32'(wr_en[i]), 32'd0);
      check($sformatf("reset dut%0d wr_addr", i),    wr_addr[i], 32'd0);
      check($sformatf("reset dut%0d wr_data", i),    wr_data[i], 32'd0);
      check($sformatf("reset dut%0d tx_valid", i),   32'(tx_valid[i]), 32'd0);
      check($sformatf("reset dut%0d tx_data", i),    32'(tx_data[i]), 32'd0);
      check($sformatf("reset dut%0d core_start", i), 32'(core_start[i]), 32'd0);
      check($sformatf("reset dut%0d load_err", i),   32'(load_err[i]), 32'd0);
      obs_addr[i].delete();
      obs_data[i].delete();
      obs_tx[i].delete();
    end
    tick();
    rst = 1'b0;
  endtask

  // Behavioural reference: parse the stream as a count followed by that many words.
  task automatic model(input int i);
    logic [31:0] n;
    n = {stim[3], stim[2], stim[1], stim[0]};
    exp_addr[i].delete();
    exp_data[i].delete();
    exp_err[i] = (n > max_of(i));
    exp_tx[i]  = exp_err[i] ? NAK : ACK;
    if (!exp_err[i]) begin
      for (int k = 0; k < int'(n); k++) begin
        exp_addr[i].push_back(base_of(i) + 32'(k));
        exp_data[i].push_back({stim[4*k+7], stim[4*k+6], stim[4*k+5], stim[4*k+4]});
      end
    end
  endtask

  // Reset, play the stream, release tx_ready, then send bytes that must be ignored.
  task automatic drive(input int gap_max, input int ready_delay);
    do_reset();
    foreach (stim[j]) begin
      send(stim[j]);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
    end
    repeat (ready_delay) tick();
    tx_ready = 1'b1;
    repeat (3) tick();
    repeat (3) send(8'($urandom));
    repeat (2) tick();
  endtask

  task automatic verify(input int i);
    int na, ne;
    na = obs_addr[i].size();
    ne = exp_addr[i].size();
    check($sformatf("%s dut%0d wr_count", tag, i), 32'(na), 32'(ne));
    for (int k = 0; k < na && k < ne; k++) begin
      check($sformatf("%s dut%0d wr_addr[%0d]", tag, i, k), obs_addr[i][k], exp_addr[i][k]);
      check($sformatf("%s dut%0d wr_data[%0d]", tag, i, k), obs_data[i][k], exp_data[i][k]);
    end
    check($sformatf("%s dut%0d tx_count", tag, i), 32'(obs_tx[i].size()), 32'd1);
    if (obs_tx[i].size() > 0)
      check($sformatf("%s dut%0d tx_byte", tag, i), 32'(obs_tx[i][0]), 32'(exp_tx[i]));
    check($sformatf("%s dut%0d load_err", tag, i),   32'(load_err[i]), 32'(exp_err[i]));
    check($sformatf("%s dut%0d core_start", tag, i), 32'(core_start[i]), 32'(!exp_err[i]));
    check($sformatf("%s dut%0d tx_valid_idle", tag, i), 32'(tx_valid[i]), 32'd0);
  endtask

  task automatic finish_check();
    @(negedge clk);
    verify(0);
    verify(1);
    tick();
    tx_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] n;
    int          nw;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; tx_ready = 1'b0;

    vecs[0] = mk(32'd2, 2, {32'h0, 32'h0, 32'h0, 32'h0, 32'h00100093, 32'h00000013}, 0, 0, 2, 2);
    vecs[1] = mk(32'd0, 0, '0, 0, 0, 0, 0);
    vecs[2] = mk(32'd5, 5, {32'h0, 32'h55555555, 32'h44444444, 32'hDEADBEEF, 32'h01234567, 32'hFFFFFFFF}, 0, 1, 5, 0);
    vecs[3] = mk(32'd3, 3, {32'h0, 32'h0, 32'h0, 32'hC0FFEE00, 32'h000000FF, 32'h80000001}, 0, 0, 3, 3);
    vecs[4] = mk(32'd4, 4, {32'h0, 32'h0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0}, 0, 0, 4, 4);
    vecs[5] = mk(32'd4097, 0, '0, 1, 1, 0, 0);
    vecs[6] = mk(32'hFFFFFFFF, 0, '0, 1, 1, 0, 0);
    vecs[7] = mk(32'd1, 1, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h87654321}, 0, 0, 1, 1);

    // Directed table: bytes back to back, expectations taken from the table itself.
    for (int v = 0; v < 8; v++) begin
      tag = $sformatf("vec%0d", v);
      stim.delete();
      push_word(vecs[v].n);
      for (int k = 0; k < vecs[v].nw; k++) push_word(vecs[v].w[k]);
      drive(0, v % 3);
      for (int i = 0; i < 2; i++) begin
        exp_err[i] = (i == 0) ? vecs[v].err_a : vecs[v].err_b;
        exp_tx[i]  = exp_err[i] ? NAK : ACK;
        exp_addr[i].delete();
        exp_data[i].delete();
        for (int k = 0; k < ((i == 0) ? vecs[v].cnt_a : vecs[v].cnt_b); k++) begin
          exp_addr[i].push_back(base_of(i) + 32'(k));
          exp_data[i].push_back(vecs[v].w[k]);
        end
      end
      finish_check();
    end

    // Randomized loads with random idle gaps, checked against the reference model.
    for (int r = 0; r < 16; r++) begin
      tag = $sformatf("rand%0d", r);
      stim.delete();
      if ($urandom_range(0, 4) == 0) begin
        n  = 32'($urandom) | 32'h0000_2000;
        nw = $urandom_range(0, 2);
      end else begin
        n  = 32'($urandom_range(0, 6));
        nw = int'(n);
      end
      push_word(n);
      for (int k = 0; k < nw; k++) push_word(32'($urandom));
      drive(r % 3 + ((r == 5) ? 20 : 0), $urandom_range(0, 5));
      model(0);
      model(1);
      finish_check();
    end

    // N=1, consecutive data bytes, tx_ready held low for 10 cycles.
    tag = "hold";
    do_reset();
    send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33);
    rx_data  = 8'h44;
    rx_valid = 1'b1;
    @(negedge clk);
    check("hold wr_en_on_4th_byte", 32'(wr_en[0]), 32'd0);
    tick();
    rx_valid = 1'b0;
    @(negedge clk);
    check("hold wr_en_after_4th_byte", 32'(wr_en[0]), 32'd1);
    check("hold wr_addr", wr_addr[0], 32'h0);
    check("hold wr_data", wr_data[0], 32'h44332211);
    check("hold wr_addr_base", wr_addr[1], 32'h100);
    for (int j = 0; j < 10; j++) begin
      if (j == 1) check("hold wr_en_single_cycle", 32'(wr_en[0]), 32'd0);
      check($sformatf("hold tx_valid_c%0d", j), 32'(tx_valid[0]), 32'd1);
      check($sformatf("hold tx_data_c%0d", j), 32'(tx_data[0]), 32'(ACK));
      check($sformatf("hold core_start_c%0d", j), 32'(core_start[0]), 32'd0);
      @(negedge clk);
    end
    tick();
    tx_ready = 1'b1;
    @(negedge clk);
    check("hold core_start_at_ready", 32'(core_start[0]), 32'd0);
    check("hold tx_valid_at_ready", 32'(tx_valid[0]), 32'd1);
    tick();
    @(negedge clk);
    check("hold core_start_after_ready", 32'(core_start[0]), 32'd1);
    check("hold tx_valid_after_ready", 32'(tx_valid[0]), 32'd0);
    tick();
    tx_ready = 1'b0;

    // Reset mid-load after 6 data bytes, then a clean one-word load.
    tag = "midreset";
    do_reset();
    send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    for (int j = 0; j < 6; j++) send(8'(8'hA0 + j));
    do_reset();
    send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("midreset dut%0d wr_count", i), 32'(obs_addr[i].size()), 32'd1);
      if (obs_addr[i].size() > 0) begin
        check($sformatf("midreset dut%0d wr_addr", i), obs_addr[i][0], base_of(i));
        check($sformatf("midreset dut%0d wr_data", i), obs_data[i][0], 32'h12345678);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
